// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: bundles the three requester channels, the grant and
// completion signals, and the shared memory bus command/response.
//
// Handshake: a requester holds req[i] with its command fields stable until
// gnt[i] rises; the arbiter latches the command at grant time, so later
// changes are ignored. Completion is the single-cycle ack[i] pulse, with rdata
// valid in that same cycle. On the memory side the arbiter holds bus_read or
// bus_write with a stable address and data until it samples bus_ready high.
interface bus_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [23:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [7:0]  rdata;
    logic [7:0]  bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ready;
    logic        busy;
    logic        timeout_err;

    // Arbiter side
    modport slave (
        input  req, req_we, req_addr, req_wdata, bus_rdata, bus_ready,
        output gnt, ack, rdata, bus_addr, bus_read, bus_write, bus_wdata,
               busy, timeout_err
    );

    // Requester / memory model side
    modport master (
        output req, req_we, req_addr, req_wdata, bus_rdata, bus_ready,
        input  gnt, ack, rdata, bus_addr, bus_read, bus_write, bus_wdata,
               busy, timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: three-requester arbiter for a shared 8-bit memory bus.
// The FSM goes IDLE -> XFER -> DONE. A transaction that waits WAIT_LIMIT
// cycles without bus_ready is aborted, returns 8'hFF and sets the sticky
// timeout_err flag.
// Optional feature macro ARB_ROUND_ROBIN_EN: round-robin arbitration using a
// rotating pointer. When it is undefined, fixed priority is used
// (loader bit0 > data bit1 > fetch bit2).
module bus_arbiter #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT_B = 8'(WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [2:0] ack_q, ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] bus_addr_q, bus_addr_d;
    logic [7:0] bus_wdata_q, bus_wdata_d;
    logic       bus_read_q, bus_read_d;
    logic       bus_write_q, bus_write_d;
    logic [7:0] wait_q, wait_d;
    logic       terr_q, terr_d;
    logic [1:0] win_idx;
    logic [2:0] win_onehot;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand0, cand1, cand2;
    logic [1:0] owner_idx;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin pick: first requesting index at or above the pointer, wrapping
    always_comb begin
        cand0 = ptr_q;
        cand1 = next_idx(ptr_q);
        cand2 = next_idx(cand1);
        win_idx = cand2;
        if (bus.req[cand1]) win_idx = cand1;
        if (bus.req[cand0]) win_idx = cand0;
    end

    // Index of the current owner, recovered from the one-hot grant
    always_comb begin
        owner_idx = 2'd0;
        if (gnt_q[1]) owner_idx = 2'd1;
        if (gnt_q[2]) owner_idx = 2'd2;
    end
`else
    // Fixed priority pick: loader, then data, then fetch
    always_comb begin
        win_idx = 2'd2;
        if (bus.req[1]) win_idx = 2'd1;
        if (bus.req[0]) win_idx = 2'd0;
    end
`endif

    assign win_onehot = 3'b001 << win_idx;

    // Next-state and next-output logic; defaults hold or clear each register
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        wait_d      = wait_q;
        terr_d      = terr_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Latch the winner's command; it stays frozen for the whole XFER
                if (|bus.req) begin
                    state_d     = XFER;
                    gnt_d       = win_onehot;
                    bus_addr_d  = bus.req_addr[{win_idx, 3'b000} +: 8];
                    bus_wdata_d = bus.req_wdata[{win_idx, 3'b000} +: 8];
                    bus_read_d  = ~bus.req_we[win_idx];
                    bus_write_d = bus.req_we[win_idx];
                    wait_d      = 8'd0;
                end
            end
            XFER: begin
                if (bus.bus_ready) begin
                    state_d = DONE;
                    rdata_d = bus.bus_rdata;
                    ack_d   = gnt_q;
                end else if (wait_q == WAIT_LIMIT_B) begin
                    state_d = DONE;
                    rdata_d = 8'hFF;
                    terr_d  = 1'b1;
                    ack_d   = gnt_q;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
                // Leaving XFER drops the bus command for the DONE cycle
                if (state_d == DONE) begin
                    bus_addr_d  = 8'd0;
                    bus_wdata_d = 8'd0;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
                ptr_d   = next_idx(owner_idx);
`endif
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 3'b000;
                bus_read_d  = 1'b0;
                bus_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset drops the bus command at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 3'b000;
            ack_q       <= 3'b000;
            rdata_q     <= 8'd0;
            bus_addr_q  <= 8'd0;
            bus_wdata_q <= 8'd0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            wait_q      <= 8'd0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            wait_q      <= wait_d;
            terr_q      <= terr_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end
`endif

    assign bus.gnt         = gnt_q;
    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wdata   = bus_wdata_q;
    assign bus.bus_read    = bus_read_q;
    assign bus.bus_write   = bus_write_q;
    assign bus.busy        = (state_q == XFER);
    assign bus.timeout_err = terr_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: randomized transactions checked against a
// transaction-level reference (winner pick, transfer length, read data,
// sticky abort flag) plus directed cases for contention, wait states,
// timeout, request drop and reset during a transfer.
module tb_bus_arbiter;

    localparam int WL = 15;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    bus_arbiter_if bif ();

    bus_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];
    int         m_ptr    = 0;
    logic       m_terr   = 1'b0;
    int         w;

`ifdef ARB_ROUND_ROBIN_EN
    int exp_order[4] = '{0, 1, 2, 0};
`else
    int exp_order[4] = '{0, 0, 0, 0};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first requesting index searching up from p, wrapping
    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (p + k) % 3;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // ---------------- driver: one full transaction ----------------
    // Entered and left at a falling edge while the DUT is in IDLE.
    // delay = number of XFER cycles with bus_ready low before it rises.
    task automatic do_txn(input logic [2:0] r, input int delay, input bit drop,
                          input logic [2:0] we, output int win);
        logic [7:0] a[3];
        logic [7:0] d[3];
        logic [7:0] exp_rd;
        logic [2:0] oh;
        int         len;
        int         wcnt;
        for (int i = 0; i < 3; i++) begin
            a[i] = 8'($urandom);
            d[i] = 8'($urandom);
        end
        bif.req       = r;
        bif.req_we    = we;
        bif.req_addr  = {a[2], a[1], a[0]};
        bif.req_wdata = {d[2], d[1], d[0]};
        bif.bus_ready = 1'b0;
        win    = pick(r, m_ptr);
        oh     = 3'(1 << win);
        exp_q.push_back(oh);
        len    = ((delay < WL) ? delay : WL) + 1;
        exp_rd = 8'hFF;
        wcnt   = 0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            chk("gnt",       32'(bif.gnt),       32'(oh));
            chk("busy",      32'(bif.busy),      32'd1);
            chk("ack_xfer",  32'(bif.ack),       32'd0);
            chk("bus_addr",  32'(bif.bus_addr),  32'(a[win]));
            chk("bus_wdata", 32'(bif.bus_wdata), 32'(d[win]));
            chk("bus_read",  32'(bif.bus_read),  32'(!we[win]));
            chk("bus_write", 32'(bif.bus_write), 32'(we[win]));
            if (bif.bus_write) wcnt++;
            // Scramble requester inputs: the latched command must not follow
            bif.req_we    = 3'($urandom);
            bif.req_addr  = 24'($urandom);
            bif.req_wdata = 24'($urandom);
            if (drop) bif.req = r & ~oh;
            bif.bus_ready = (c == delay);
            bif.bus_rdata = 8'($urandom);
            if (c == delay) exp_rd = bif.bus_rdata;
        end
        if (delay > WL) m_terr = 1'b1;
        @(negedge clk);  // DONE cycle
        chk("ack",        32'(bif.ack),         32'(exp_q.pop_front()));
        chk("rdata",      32'(bif.rdata),       32'(exp_rd));
        chk("done_read",  32'(bif.bus_read),    32'd0);
        chk("done_write", 32'(bif.bus_write),   32'd0);
        chk("done_busy",  32'(bif.busy),        32'd0);
        chk("timeout",    32'(bif.timeout_err), 32'(m_terr));
        chk("wr_cycles",  32'(wcnt),            32'(we[win] ? len : 0));
        bif.bus_ready = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        m_ptr = (win + 1) % 3;
`endif
        @(negedge clk);  // IDLE cycle: no bypass, ack was a single pulse
        chk("idle_ack",   32'(bif.ack),       32'd0);
        chk("idle_gnt",   32'(bif.gnt),       32'd0);
        chk("idle_busy",  32'(bif.busy),      32'd0);
        chk("idle_read",  32'(bif.bus_read),  32'd0);
        chk("idle_write", 32'(bif.bus_write), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bif.req       = 3'b000;
        bif.req_we    = 3'b000;
        bif.req_addr  = 24'd0;
        bif.req_wdata = 24'd0;
        bif.bus_rdata = 8'd0;
        bif.bus_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_gnt",   32'(bif.gnt),         32'd0);
        chk("rst_ack",   32'(bif.ack),         32'd0);
        chk("rst_rdata", 32'(bif.rdata),       32'd0);
        chk("rst_addr",  32'(bif.bus_addr),    32'd0);
        chk("rst_wdata", 32'(bif.bus_wdata),   32'd0);
        chk("rst_read",  32'(bif.bus_read),    32'd0);
        chk("rst_write", 32'(bif.bus_write),   32'd0);
        chk("rst_busy",  32'(bif.busy),        32'd0);
        chk("rst_terr",  32'(bif.timeout_err), 32'd0);
        chk("rst_state", 32'(dbg_state),       32'd0);
        rst_n = 1'b1;

        // No request: stays idle with the bus quiet
        repeat (3) @(negedge clk);
        chk("noreq_gnt",   32'(bif.gnt),      32'd0);
        chk("noreq_read",  32'(bif.bus_read), 32'd0);
        chk("noreq_state", 32'(dbg_state),    32'd0);

        // Contention with all requests held
        for (int i = 0; i < 4; i++) begin
            do_txn(3'b111, 0, 1'b0, 3'($urandom), w);
            chk("order", 32'(w), 32'(exp_order[i]));
        end

        // Single fetch read, zero wait
        do_txn(3'b100, 0, 1'b0, 3'b000, w);
        // Write with four wait states
        do_txn(3'b010, 4, 1'b0, 3'b111, w);
        // Ready arrives exactly at the limit: completes normally
        do_txn(3'b001, WL, 1'b0, 3'b000, w);
        // Stuck bus: timeout
        do_txn(3'b100, WL + 5, 1'b0, 3'b000, w);
        // One past the limit also aborts; flag stays set
        do_txn(3'b010, WL + 1, 1'b0, 3'($urandom), w);
        // Data requester drops req during XFER
        do_txn(3'b010, 2, 1'b1, 3'($urandom), w);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 5);
            do_txn(3'($urandom_range(1, 7)), dly, 1'($urandom_range(0, 1)),
                   3'($urandom), w);
        end

        // Reset during a write transfer
        bif.req       = 3'b010;
        bif.req_we    = 3'b010;
        bif.bus_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_write", 32'(bif.bus_write), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_write", 32'(bif.bus_write), 32'd0);
        chk("async_read",  32'(bif.bus_read),  32'd0);
        chk("async_gnt",   32'(bif.gnt),       32'd0);
        chk("async_busy",  32'(bif.busy),      32'd0);
        chk("async_terr",  32'(bif.timeout_err), 32'd0);
        @(negedge clk);
        chk("rst_no_ack",  32'(bif.ack), 32'd0);
        bif.req = 3'b000;
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_terr  = 1'b0;
        exp_q.delete();
        @(negedge clk);

        // Fresh request after reset completes normally
        do_txn(3'b010, 1, 1'b0, 3'b010, w);
        do_txn(3'b101, 0, 1'b0, 3'($urandom), w);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit in case the stimulus ever stalls
    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout_guard got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, sets the maximum bus wait cycles before a transaction aborts (range 1-255).
REQ-002 Port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-004 Port req, input, 3, per-requester request: bit0 = instruction-memory loader, bit1 = data load/store, bit2 = instruction fetch.
REQ-005 Port req_we, input, 3, per-requester write flag (1 = write, 0 = read).
REQ-006 Port req_addr, input, 24, per-requester 8-bit address; requester i occupies bits [8i+7:8i].
REQ-007 Port req_wdata, input, 24, per-requester 8-bit write data, packed the same way as req_addr.
REQ-008 Port gnt, output, 3, one-hot grant to the owning requester; all zero when idle.
REQ-009 Port ack, output, 3, one-cycle completion pulse to the owning requester.
REQ-010 Port rdata, output, 8, read data; valid in the ack cycle.
REQ-011 Port bus_addr, output, 8; bus_read, output, 1; bus_write, output, 1; bus_wdata, output, 8. Together these are the shared memory bus command.
REQ-012 Port bus_rdata, input, 8; bus_ready, input, 1. These carry the memory response.
REQ-013 Port busy, output, 1, high while in XFER; timeout_err, output, 1, sticky abort flag.

Function
REQ-014 The FSM SHALL have states IDLE, XFER and DONE, encoded in 2 bits.
REQ-015 IDLE: if any req bit is high, the block SHALL pick one winner, register gnt, latch that requester's addr, wdata and we, and move to XFER on the next edge.
REQ-016 With no request, the FSM SHALL remain in IDLE with all bus outputs low.
REQ-017 XFER: the block SHALL drive bus_addr and bus_wdata from the latched values, with bus_read = !we and bus_write = we.
REQ-018 XFER SHALL wait until bus_ready is sampled high, then capture bus_rdata into rdata and move to DONE.
REQ-019 An 8-bit wait counter SHALL clear on entry to XFER and increment each XFER cycle in which bus_ready is low.
REQ-020 When the wait counter equals WAIT_LIMIT with bus_ready still low, the block SHALL set timeout_err, force rdata to 8'hFF and move to DONE.
REQ-021 DONE: the block SHALL pulse ack[winner] for exactly one cycle, deassert the bus command, clear gnt and return to IDLE.
REQ-022 The minimum transaction time SHALL be 3 cycles from req to ack when bus_ready is already high in the first XFER cycle.
REQ-023 Latched command values SHALL NOT change during XFER, even if the requester alters its inputs.
REQ-024 If a requester drops req during XFER, the transaction SHALL still complete and ack SHALL still pulse.
REQ-025 A requester holding req through ack SHALL re-enter arbitration in the next IDLE cycle, with no back-to-back bypass.
REQ-026 Fixed priority SHALL be loader > data > fetch.
REQ-027 With simultaneous requests, exactly one grant SHALL be issued; gnt SHALL never have more than one bit set.
REQ-028 busy SHALL equal (state == XFER).

Reset
REQ-029 While rst_n is low, the FSM SHALL be in IDLE, with gnt = 0, ack = 0, rdata = 0, bus_addr = 0, bus_wdata = 0, bus_read = 0, bus_write = 0, wait counter = 0, timeout_err = 0 and the round-robin pointer = 0.
REQ-030 Reset asserted mid-XFER SHALL deassert bus_read and bus_write immediately, without waiting for a clock, and SHALL issue no ack.
REQ-031 timeout_err SHALL clear only on reset.

Configuration
REQ-032 The feature macro SHALL be ARB_ROUND_ROBIN_EN.
REQ-033 With ARB_ROUND_ROBIN_EN defined, a 2-bit pointer SHALL advance to (winner+1) mod 3 in DONE, and arbitration SHALL search from the pointer upward, wrapping from 2 to 0.
REQ-034 Without ARB_ROUND_ROBIN_EN, the pointer logic SHALL be absent and the fixed priority of REQ-026 SHALL apply.

Verification
REQ-035 Single read: req = 3'b100, addr2 = 8'h10, bus_ready high -> gnt = 3'b100 one cycle after req, bus_read = 1 with bus_addr = 8'h10, ack = 3'b100 with rdata = bus_rdata at cycle 3.
REQ-036 Contention, fixed priority: req = 3'b111 held -> grant order loader, loader, loader (loader starves the others); with ARB_ROUND_ROBIN_EN -> grant order 0, 1, 2, 0.
REQ-037 Wait states: bus_ready low for 4 cycles, write to addr 8'h20 with wdata 8'hA5 -> bus_write held for 5 cycles, bus_wdata stable at 8'hA5, a single ack pulse.
REQ-038 Timeout: bus_ready stuck low -> DONE after WAIT_LIMIT = 15 wait cycles, timeout_err = 1, rdata = 8'hFF, bus idle afterwards.
REQ-039 Reset mid-XFER: rst_n low during a write -> bus_write = 0 before the next edge, no ack; a fresh request after reset completes normally.
REQ-040 Request dropped mid-XFER: req[1] dropped during XFER -> ack[1] still pulses once, then the FSM returns to IDLE.
